// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } rst_seq_state_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 8;
  localparam int DEF_CNT_W       = 8;

  // Wide enough to hold the larger of the two limits without wrapping.
  function automatic int rst_seq_tmr_w(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear; o_expire flags the last cycle of an
// i_limit-cycle interval.
module rst_seq_timer #(
  parameter int W = 5
) (
  input  logic         sysclk,
  input  logic         sys_rstn,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn)  r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= r_cnt + W'(1);
  end

  assign o_expire = (r_cnt == i_limit - W'(1));

endmodule

// File: rtl/reset_release_sequencer.sv
// Ordered active-low reset release with hold/gap timing and ATPG bypass.
// Define RST_SEQ_EVT_CNT_EN to build the saturating request-edge counter.
module reset_release_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  sysclk,
  input  logic                  sys_rstn,
  input  logic                  evt_rst_req,
  input  logic                  ATPG_TM,
  input  logic                  ATPG_RSTN,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_busy,
  output logic [CNT_W-1:0]      event_cnt
);

  localparam int TW = rst_seq_tmr_w(HOLD_CYCLES, GAP_CYCLES);

  localparam logic [1:0] S_ASSERT  = ASSERT;
  localparam logic [1:0] S_RELEASE = RELEASE;
  localparam logic [1:0] S_IDLE    = IDLE;

  generate
    if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
      $error("NUM_STAGES must be 1..8");
    end
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_timing
      $error("HOLD_CYCLES and GAP_CYCLES must be >= 1");
    end
  endgenerate

  logic [1:0]            r_state;
  logic [NUM_STAGES-1:0] r_rel;
  logic [NUM_STAGES-1:0] w_rel_nxt;
  logic [TW-1:0]         w_limit;
  logic                  w_clr;
  logic                  w_expire;

  // Released stages form a thermometer code, so shifting in a one releases
  // exactly the next stage in index order.
  assign w_rel_nxt = (r_rel << 1) | NUM_STAGES'(1);
  assign w_limit   = (r_state == S_ASSERT) ? TW'(HOLD_CYCLES) : TW'(GAP_CYCLES);
  assign w_clr     = evt_rst_req | w_expire | (r_state == S_IDLE);

  rst_seq_timer #(.W(TW)) u_timer (
    .sysclk   (sysclk),
    .sys_rstn (sys_rstn),
    .i_clr    (w_clr),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state <= S_ASSERT;
      r_rel   <= '0;
    end else if (evt_rst_req) begin
      // A request beats any release due on the same edge.
      r_state <= S_ASSERT;
      r_rel   <= '0;
    end else begin
      case (r_state)
        S_ASSERT, S_RELEASE: begin
          if (w_expire) begin
            r_rel   <= w_rel_nxt;
            r_state <= (&w_rel_nxt) ? S_IDLE : S_RELEASE;
          end
        end
        S_IDLE: ;
        default: begin
          r_state <= S_ASSERT;
          r_rel   <= '0;
        end
      endcase
    end
  end

  assign seq_busy  = (r_state != S_IDLE);
  assign rst_n_out = ATPG_TM ? {NUM_STAGES{ATPG_RSTN}} : r_rel;

`ifdef RST_SEQ_EVT_CNT_EN
  logic             r_req_d;
  logic [CNT_W-1:0] r_evt_cnt;

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_req_d   <= 1'b0;
      r_evt_cnt <= '0;
    end else begin
      r_req_d <= evt_rst_req;
      if (evt_rst_req && !r_req_d && !(&r_evt_cnt))
        r_evt_cnt <= r_evt_cnt + CNT_W'(1);
    end
  end

  assign event_cnt = r_evt_cnt;
`else
  assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench: stimulus queues per-edge expectations, monitor checks them.
module tb_reset_release_sequencer;

  logic       sysclk;
  logic       sys_rstn;
  logic       evt_rst_req;
  logic       ATPG_TM;
  logic       ATPG_RSTN;
  logic [3:0] rst_n_out;
  logic       seq_busy;
  logic [7:0] event_cnt;

  reset_release_sequencer #(
    .NUM_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(8)
  ) dut (
    .sysclk      (sysclk),
    .sys_rstn    (sys_rstn),
    .evt_rst_req (evt_rst_req),
    .ATPG_TM     (ATPG_TM),
    .ATPG_RSTN   (ATPG_RSTN),
    .rst_n_out   (rst_n_out),
    .seq_busy    (seq_busy),
    .event_cnt   (event_cnt)
  );

  typedef struct {
    int         at;
    logic [3:0] rst;
    logic       busy;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   ecnt  = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   mcnt  = 0;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int at, input logic [3:0] r, input logic b, input string nm);
    exp_t e;
    e.at = at; e.rst = r; e.busy = b; e.cnt = mcnt[7:0]; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic bump();
`ifdef RST_SEQ_EVT_CNT_EN
    if (mcnt < 255) mcnt++;
`endif
  endtask

  task automatic wait_ec(input int t);
    while (ecnt < t) @(negedge sysclk);
  endtask

  // One-cycle request; a = edge that samples it high. Returns at the negedge
  // after the first low sample (edge a+1).
  task automatic pulse(output int a, input string nm);
    evt_rst_req = 1'b1;
    a = ecnt + 1;
    bump();
    push(a, 4'b0000, 1'b1, nm);
    @(negedge sysclk);
    evt_rst_req = 1'b0;
    @(negedge sysclk);
  endtask

  // Full release after first low request sample at edge k.
  task automatic expect_rel(input int k, input string nm);
    push(k + 14, 4'b0000, 1'b1, {nm, "_hold"});
    push(k + 15, 4'b0001, 1'b1, {nm, "_s0"});
    push(k + 22, 4'b0001, 1'b1, {nm, "_pre_s1"});
    push(k + 23, 4'b0011, 1'b1, {nm, "_s1"});
    push(k + 30, 4'b0011, 1'b1, {nm, "_pre_s2"});
    push(k + 31, 4'b0111, 1'b1, {nm, "_s2"});
    push(k + 38, 4'b0111, 1'b1, {nm, "_pre_s3"});
    push(k + 39, 4'b1111, 1'b0, {nm, "_s3_idle"});
  endtask

  // Monitor: one sample per cycle, just after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sysclk);
      #3;
      while (q.size() > 0 && q[0].at <= ecnt) begin
        e = q.pop_front();
        if (e.at < ecnt) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s: expectation for edge %0d reached at %0d", e.nm, e.at, ecnt);
        end else begin
          chk({e.nm, "/rst_n_out"}, {28'd0, rst_n_out}, {28'd0, e.rst});
          chk({e.nm, "/seq_busy"},  {31'd0, seq_busy},  {31'd0, e.busy});
          chk({e.nm, "/event_cnt"}, {24'd0, event_cnt}, {24'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    int a;
    int k;
    sys_rstn    = 1'b0;
    evt_rst_req = 1'b0;
    ATPG_TM     = 1'b0;
    ATPG_RSTN   = 1'b0;
    push(2, 4'b0000, 1'b1, "reset_state");
    repeat (3) @(negedge sysclk);

    // Power-up sequence, no request.
    sys_rstn = 1'b1;
    k = ecnt + 1;
    expect_rel(k, "pwrup");
    wait_ec(k + 45);

    // Single-cycle pulse from IDLE.
    pulse(a, "pulse1");
    expect_rel(a + 1, "rel1");
    wait_ec(a + 45);

    // Request lands on the stage-2 release edge.
    pulse(a, "pulse2");
    k = a + 1;
    push(k + 15, 4'b0001, 1'b1, "abort_s0");
    push(k + 23, 4'b0011, 1'b1, "abort_s1");
    push(k + 30, 4'b0011, 1'b1, "abort_pre_s2");
    wait_ec(k + 30);
    pulse(a, "abort_hit");
    expect_rel(a + 1, "rel_abort");
    wait_ec(a + 45);

    // Scan bypass while the FSM holds everything in ASSERT.
    pulse(a, "pulse_atpg");
    wait_ec(a + 2);
    ATPG_TM = 1'b1; ATPG_RSTN = 1'b1;
    #1 chk("atpg_hi", {28'd0, rst_n_out}, 32'hF);
    chk("atpg_busy", {31'd0, seq_busy}, 32'd1);
    ATPG_RSTN = 1'b0;
    #1 chk("atpg_lo", {28'd0, rst_n_out}, 32'h0);
    ATPG_RSTN = 1'b1;
    #1 chk("atpg_hi2", {28'd0, rst_n_out}, 32'hF);
    push(ecnt + 1, 4'b1111, 1'b1, "atpg_edge");
    @(negedge sysclk);
    ATPG_TM = 1'b0;
    push(ecnt + 1, 4'b0000, 1'b1, "atpg_off");
    expect_rel(a + 1, "rel_atpg");
    wait_ec(a + 45);

    // Counter saturation.
    for (int i = 0; i < 300; i++) pulse(a, $sformatf("sat%0d", i));
    expect_rel(a + 1, "rel_sat");
    wait_ec(a + 45);

    // Async reset in the stage-1 gap.
    pulse(a, "pulse_ar");
    k = a + 1;
    push(k + 15, 4'b0001, 1'b1, "ar_s0");
    push(k + 17, 4'b0001, 1'b1, "ar_gap");
    wait_ec(k + 18);
    #1 sys_rstn = 1'b0;
    #1 chk("ar_rst_n_out", {28'd0, rst_n_out}, 32'h0);
    chk("ar_busy", {31'd0, seq_busy}, 32'd1);
    chk("ar_cnt", {24'd0, event_cnt}, 32'd0);
    @(negedge sysclk);
    sys_rstn = 1'b1;
    mcnt = 0;
    k = ecnt + 1;
    expect_rel(k, "rel_ar");
    wait_ec(k + 42);

    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Downstream of the asynchronous reset-event catcher: consumes its sysclk-synchronous reset request and produces NUM_STAGES ordered active-low reset outputs for the rest of the chip. All stages assert together when a request arrives. After the request clears and a minimum hold time elapses, the stages release one at a time in index order, with a fixed gap between stages. An ATPG bypass gives scan direct control of every output.

## Interface
Parameters:
- NUM_STAGES, 4, number of reset outputs; legal range 1..8
- HOLD_CYCLES, 16, sysclk cycles all stages stay low after the request drops; must be ≥1
- GAP_CYCLES, 8, sysclk cycles between consecutive stage releases; must be ≥1
- CNT_W, 8, width of the event counter

Ports:
- sysclk  in  1  system clock; single clock domain
- sys_rstn  in  1  asynchronous active-low reset
- evt_rst_req  in  1  active-high reset request; level signal, driven from a sysclk flop upstream
- ATPG_TM  in  1  scan test mode
- ATPG_RSTN  in  1  scan-controlled reset, active-low
- rst_n_out  out  NUM_STAGES  ordered active-low resets; bit 0 releases first
- seq_busy  out  1  high while any stage is held in reset by the FSM
- event_cnt  out  CNT_W  saturating count of request rising edges

## Operation
- Clock and reset: single clock sysclk; reset sys_rstn is asynchronous and active-low.
- Reset values: rst_n_out = all 0, seq_busy = 1, event_cnt = 0, FSM = ASSERT, timer = 0.
- Leaving sys_rstn runs a full release sequence with no request present. The chip therefore always comes up in stage order.
- FSM states: ASSERT, RELEASE, IDLE.
- ASSERT behaviour:
  - All outputs are low.
  - While evt_rst_req = 1, the timer is held at 0.
  - While evt_rst_req = 0, the timer increments.
  - When timer = HOLD_CYCLES−1, the FSM moves to RELEASE: stage 0 releases, stage index = 0, timer = 0.
- RELEASE behaviour:
  - The timer counts to GAP_CYCLES−1, then the next stage releases.
  - When the last stage releases, the FSM moves to IDLE.
- IDLE behaviour: all outputs are high and seq_busy = 0.
- evt_rst_req = 1 in RELEASE or IDLE:
  - Next edge: all outputs go low, seq_busy = 1, FSM = ASSERT, timer = 0.
  - Any partial release is aborted.
- Released stages stay released until the next request or reset. No stage ever rises out of index order.
- Test mode:
  - ATPG_TM = 1 makes rst_n_out = {NUM_STAGES{ATPG_RSTN}} combinationally. The FSM keeps running underneath.
  - seq_busy and event_cnt are not affected by test mode.
- Timer width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1). The timer compares for equality and never wraps.

## Timing
- Request assert latency: evt_rst_req sampled high at edge n causes rst_n_out = 0 after edge n. This is one cycle.
- Release timing, with the first low sample of evt_rst_req at edge k:
  - rst_n_out[i] rises after edge k+HOLD_CYCLES−1+i·GAP_CYCLES.
  - seq_busy falls on the same edge as rst_n_out[NUM_STAGES−1].
- A request pulse that lasts one cycle still produces the full HOLD_CYCLES hold.
- Request asserted on the same edge as a stage release: the request wins and all outputs go low.
- Request toggling inside ASSERT restarts the hold count from 0 each time it drops.
- sys_rstn asserted mid-sequence: all flops return to reset values immediately, independent of sysclk.

## Configuration
- RST_SEQ_EVT_CNT_EN defined:
  - event_cnt increments on each 0→1 transition of evt_rst_req, detected with a registered copy of evt_rst_req.
  - The count saturates at 2^CNT_W−1.
- RST_SEQ_EVT_CNT_EN undefined:
  - The edge detector and counter are not built.
  - event_cnt is tied to 0.
  - The port list does not change.

## Structure
- Shared package rst_seq_pkg holds:
  - the state enum rst_seq_state_e (ASSERT, RELEASE, IDLE);
  - default parameter constants;
  - a function computing the timer width.
- One sub-module, rst_seq_timer. It is a counter with a synchronous clear and an expire flag that compares against a limit input. The FSM instantiates it once and drives the limit with HOLD_CYCLES or GAP_CYCLES according to state.

## Test plan
- Power-up, with sys_rstn released at edge 0 and no request → rst_n_out[0..3] rise after edges 15, 23, 31, 39; seq_busy falls after edge 39.
- From IDLE, a 1-cycle evt_rst_req at edge 100 → all outputs low after edge 100; stage 0 rises after edge 116; event_cnt = 1.
- Request at the edge where stage 2 would release, during RELEASE → stage 2 stays low, all stages go low, and the hold restarts.
- ATPG_TM = 1 with ATPG_RSTN toggled 0/1 while the FSM is in ASSERT → rst_n_out follows ATPG_RSTN combinationally; seq_busy stays 1.
- 300 request pulses with CNT_W = 8 and RST_SEQ_EVT_CNT_EN defined → event_cnt saturates at 255. Without the macro → event_cnt stays 0 throughout.
- sys_rstn pulsed low during the stage-1 gap → outputs drop at once with no clock edge, then a full sequence runs.
